// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache types: opcodes, request kinds, exception causes and the issued packet.
package bp_be_dcache_pkg;

    localparam int unsigned dcache_opcode_width      = 4;
    localparam int unsigned dcache_page_offset_width = 12;
    localparam int unsigned dcache_data_width        = 64;

    typedef enum logic [dcache_opcode_width-1:0] {
        e_dcache_op_lb     = 4'b0000,
        e_dcache_op_lh     = 4'b0001,
        e_dcache_op_lw     = 4'b0010,
        e_dcache_op_ld     = 4'b0011,
        e_dcache_op_lbu    = 4'b0100,
        e_dcache_op_lhu    = 4'b0101,
        e_dcache_op_lwu    = 4'b0110,
        e_dcache_op_lrw    = 4'b0111,
        e_dcache_op_sb     = 4'b1000,
        e_dcache_op_sh     = 4'b1001,
        e_dcache_op_sw     = 4'b1010,
        e_dcache_op_sd     = 4'b1011,
        e_dcache_op_scw    = 4'b1100,
        e_dcache_op_lrd    = 4'b1101,
        e_dcache_op_scd    = 4'b1110,
        e_dcache_op_fencei = 4'b1111
    } bp_be_dcache_opcode_e;

    typedef enum logic [2:0] {
        e_req_load   = 3'd0,
        e_req_store  = 3'd1,
        e_req_lr     = 3'd2,
        e_req_sc     = 3'd3,
        e_req_fencei = 3'd4
    } bp_be_req_kind_e;

    typedef enum logic [1:0] {
        e_exc_none       = 2'b00,
        e_exc_misaligned = 2'b01,
        e_exc_illegal    = 2'b10
    } bp_be_exc_cause_e;

    typedef struct packed {
        bp_be_dcache_opcode_e                opcode;
        logic [dcache_page_offset_width-1:0] page_offset;
        logic [dcache_data_width-1:0]        data;
    } bp_be_dcache_pkt_s;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

endpackage

// File: rtl/bp_be_dcache_pkt_encode.sv
// Maps a pipeline memory request onto a dcache opcode and flags illegal or misaligned requests.
module bp_be_dcache_pkt_encode
    import bp_be_dcache_pkg::*;
(
    input  bp_be_req_kind_e      kind,
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [2:0]           vaddr_low,
    output bp_be_dcache_opcode_e opcode_c,
    output logic                 misaligned_c,
    output logic                 illegal_c
);

    always_comb begin
        opcode_c     = e_dcache_op_fencei;
        misaligned_c = 1'b0;
        illegal_c    = 1'b0;

        case (kind)
            e_req_load: begin
                if (!is_unsigned) begin
                    opcode_c = bp_be_dcache_opcode_e'({2'b00, size});
                end else if (size == 2'd3) begin
                    opcode_c = e_dcache_op_ld;
                end else begin
                    opcode_c = bp_be_dcache_opcode_e'({2'b01, size});
                end
            end
            e_req_store: opcode_c = bp_be_dcache_opcode_e'({2'b10, size});
            e_req_lr: begin
                illegal_c = ~size[1];
                opcode_c  = size[0] ? e_dcache_op_lrd : e_dcache_op_lrw;
            end
            e_req_sc: begin
                illegal_c = ~size[1];
                opcode_c  = size[0] ? e_dcache_op_scd : e_dcache_op_scw;
            end
            e_req_fencei: opcode_c = e_dcache_op_fencei;
            default:      illegal_c = 1'b1;
        endcase

        // fencei carries no data access, so its address alignment is irrelevant
        if (kind != e_req_fencei) begin
            misaligned_c = |(vaddr_low & align_mask(size));
        end
    end

endmodule

// File: rtl/bp_be_dcache_pkt_issuer.sv
// Queues pipeline memory requests as dcache packets, replays rejected packets and
// stalls issue while a fencei writeback is outstanding.
module bp_be_dcache_pkt_issuer
    import bp_be_dcache_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned data_width_p        = 64,
    parameter int unsigned page_offset_width_p = 12
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic [2:0]               req_kind_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_unsigned_i,
    input  logic [vaddr_width_p-1:0] req_vaddr_i,
    input  logic [data_width_p-1:0]  req_data_i,

    output logic                     pkt_v_o,
    input  logic                     pkt_ready_i,
    output bp_be_dcache_pkt_s        pkt_o,
    input  logic                     replay_i,
    input  logic                     fencei_done_i,

    output logic                     exc_v_o,
    output logic [1:0]               exc_cause_o,
    output logic [vaddr_width_p-1:0] exc_vaddr_o
);

    localparam int unsigned fifo_depth = 2;

    typedef enum logic [0:0] {
        e_st_ready      = 1'b0,
        e_st_fence_wait = 1'b1
    } issuer_state_e;

    issuer_state_e        state_r, state_n;

    bp_be_dcache_pkt_s    fifo_mem [fifo_depth];
    logic                 fifo_wptr_r, fifo_rptr_r;
    logic [1:0]           fifo_cnt_r;
    logic                 fifo_full, fifo_empty;

    bp_be_dcache_pkt_s    replay_pkt_r;
    logic                 replay_pend_r;
    logic                 issued_r;

    bp_be_req_kind_e      req_kind;
    bp_be_dcache_opcode_e enc_opcode;
    logic                 enc_misaligned, enc_illegal;
    bp_be_dcache_pkt_s    new_pkt;

    logic                 req_hs, req_fault, push, pop;
    logic                 pkt_hs, replay_hit, issue_commit;

    assign req_kind = bp_be_req_kind_e'(req_kind_i);

    bp_be_dcache_pkt_encode u_encode (
        .kind         (req_kind),
        .size         (req_size_i),
        .is_unsigned  (req_unsigned_i),
        .vaddr_low    (req_vaddr_i[2:0]),
        .opcode_c     (enc_opcode),
        .misaligned_c (enc_misaligned),
        .illegal_c    (enc_illegal)
    );

    always_comb begin
        new_pkt             = '0;
        new_pkt.opcode      = enc_opcode;
        new_pkt.page_offset = dcache_page_offset_width'(req_vaddr_i[page_offset_width_p-1:0]);
        if (req_kind == e_req_store || req_kind == e_req_sc) begin
            new_pkt.data = dcache_data_width'(req_data_i);
        end
    end

    // Handshake qualification; reset forces both valids low in the reset cycle itself
    assign fifo_full   = (fifo_cnt_r == 2'(fifo_depth));
    assign fifo_empty  = (fifo_cnt_r == 2'd0);
    assign req_ready_o = ~reset_i & (state_r == e_st_ready) & ~fifo_full & ~replay_pend_r;
    assign pkt_v_o     = ~reset_i & (state_r == e_st_ready) & (replay_pend_r | ~fifo_empty);
    assign pkt_o       = replay_pend_r ? replay_pkt_r : fifo_mem[fifo_rptr_r];

    assign req_hs       = req_v_i & req_ready_o;
    assign req_fault    = enc_misaligned | enc_illegal;
    assign push         = req_hs & ~req_fault;
    assign pkt_hs       = pkt_v_o & pkt_ready_i;
    assign replay_hit   = replay_i & issued_r;
    // A handshake coinciding with a replay is void: the replayed packet goes first
    assign issue_commit = pkt_hs & ~replay_hit;
    assign pop          = issue_commit & ~replay_pend_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_st_ready;
        end else begin
            state_r <= state_n;
        end
    end

    // A replay aimed at the fencei sends us back to READY to reissue it
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_st_ready: begin
                if (issue_commit && pkt_o.opcode == e_dcache_op_fencei) begin
                    state_n = e_st_fence_wait;
                end
            end
            e_st_fence_wait: begin
                if (replay_hit || fencei_done_i) begin
                    state_n = e_st_ready;
                end
            end
            default: state_n = e_st_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[fifo_wptr_r] <= new_pkt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fifo_wptr_r <= 1'b0;
            fifo_rptr_r <= 1'b0;
            fifo_cnt_r  <= 2'd0;
        end else begin
            if (push) begin
                fifo_wptr_r <= ~fifo_wptr_r;
            end
            if (pop) begin
                fifo_rptr_r <= ~fifo_rptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            replay_pkt_r  <= '0;
            replay_pend_r <= 1'b0;
            issued_r      <= 1'b0;
        end else begin
            issued_r <= issue_commit;
            if (issue_commit) begin
                replay_pkt_r <= pkt_o;
            end
            if (replay_hit) begin
                replay_pend_r <= 1'b1;
            end else if (issue_commit) begin
                replay_pend_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            exc_v_o     <= 1'b0;
            exc_cause_o <= 2'(e_exc_none);
            exc_vaddr_o <= '0;
        end else begin
            exc_v_o <= req_hs & req_fault;
            if (req_hs && req_fault) begin
                exc_cause_o <= enc_misaligned ? 2'(e_exc_misaligned) : 2'(e_exc_illegal);
                exc_vaddr_o <= req_vaddr_i;
            end
        end
    end

endmodule

// File: doc/bp_be_dcache_pkt_issuer.md
BP_BE_DCACHE_PKT_ISSUER -- requirements
Module: bp_be_dcache_pkt_issuer

Interface
REQ-001 Parameters SHALL be: vaddr_width_p, 39, virtual address width; data_width_p, 64, store data width; page_offset_width_p, 12, packet page-offset width.
REQ-002 Clock and reset SHALL be a single clock clk_i and reset_i; reset_i is synchronous and active-high.
REQ-003 clk_i  in  1  clock.
REQ-004 reset_i  in  1  synchronous active-high reset.
REQ-005 req_v_i  in  1  memory request valid from the pipeline.
REQ-006 req_ready_o  out  1  issuer can accept a request this cycle.
REQ-007 req_kind_i  in  3  request kind enum: load, store, lr, sc, fencei.
REQ-008 req_size_i  in  2  0=byte, 1=half, 2=word, 3=double.
REQ-009 req_unsigned_i  in  1  zero-extend load.
REQ-010 req_vaddr_i  in  vaddr_width_p  effective address.
REQ-011 req_data_i  in  data_width_p  store or sc data.
REQ-012 pkt_v_o  out  1  dcache packet valid.
REQ-013 pkt_ready_i  in  1  dcache accepts the packet.
REQ-014 pkt_o  out  dcache packet struct width  {opcode[3:0], page_offset, data}.
REQ-015 replay_i  in  1  dcache rejects the packet it accepted in the previous cycle.
REQ-016 fencei_done_i  in  1  dcache has finished the fencei writeback.
REQ-017 exc_v_o  out  1  one-cycle exception pulse.
REQ-018 exc_cause_o  out  2  01=misaligned, 10=illegal.
REQ-019 exc_vaddr_o  out  vaddr_width_p  faulting address.

Function
REQ-020 Opcode encoding SHALL be:
- signed load: {2'b00,size}.
- unsigned load, size<3: {2'b01,size}.
- unsigned load, size=3: 4'b0011.
- store: {2'b10,size}.
- lr word/double: 4'b0111/4'b1101.
- sc word/double: 4'b1100/4'b1110.
- fencei: 4'b1111.
REQ-021 lr/sc with size<2 SHALL raise illegal and SHALL NOT be enqueued.
REQ-022 Misalignment SHALL be vaddr low bits nonzero for the access size: half bit0; word [1:0]; double [2:0]. It SHALL raise misaligned, take priority over illegal, and SHALL NOT be enqueued. fencei ignores alignment.
REQ-023 An exception SHALL fire exc_v_o in the cycle after the handshake, with exc_vaddr_o equal to the request address.
REQ-024 Accepted legal requests SHALL enter a 2-entry FIFO. page_offset SHALL be vaddr[page_offset_width_p-1:0]. data SHALL be req_data_i for store/sc and 0 otherwise.
REQ-025 Latency SHALL be one cycle: a request accepted in cycle N is on pkt_o no earlier than N+1.
REQ-026 Each issued packet (pkt_v_o & pkt_ready_i) SHALL be copied into a replay register.
REQ-027 On replay_i, the replay register SHALL be presented on pkt_o, ahead of the FIFO head, until accepted. replay_i SHALL be ignored unless a packet was issued in the previous cycle.
REQ-028 replay_i and a new handshake in the same cycle SHALL discard the new handshake: the FIFO head is not popped, and the replay packet is issued next.
REQ-029 The FSM SHALL have two states: READY and FENCE_WAIT.
- READY->FENCE_WAIT when a fencei packet is issued and not replayed.
- FENCE_WAIT->READY on fencei_done_i.
- fencei_done_i in READY is ignored.
REQ-030 req_ready_o SHALL equal: state==READY & FIFO not full & no replay pending. In FENCE_WAIT, pkt_v_o=0 and req_ready_o=0.
REQ-031 Simultaneous FIFO push and pop when full SHALL be blocked by req_ready_o=0. Push and pop when the FIFO holds 1 entry SHALL be permitted.
REQ-032 pkt_o SHALL be stable while pkt_v_o=1 and pkt_ready_i=0.

Reset
REQ-033 Reset SHALL set: FIFO empty, replay register invalid, state READY, pkt_v_o=0, exc_v_o=0, exc_cause_o=0, exc_vaddr_o=0, req_ready_o=0.
REQ-034 req_ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset mid-operation, including in FENCE_WAIT, SHALL drop all pending and replay packets.

Structure
REQ-036 The request-kind enum, the exception-cause enum and the packet struct SHALL live in bp_be_dcache_pkg, reusing bp_be_dcache_opcode_e.
REQ-037 The opcode/legality mapping SHALL be one combinational sub-module, bp_be_dcache_pkt_encode.

Verification
REQ-038 Signed lh at 0x1002 with pkt_ready_i=1 -> next cycle pkt_o opcode 4'b0001, page_offset 0x002, data 0.
REQ-039 sw at 0x1001 -> no packet; exc_v_o=1, cause 01, exc_vaddr_o 0x1001 in the next cycle.
REQ-040 lr byte -> exc cause 10, nothing issued; sc double with data 0xDEAD -> opcode 4'b1110, data 0xDEAD.
REQ-041 Issue ld at 0x8, then replay_i=1 -> the same ld reissued before the queued sb. Hold pkt_ready_i=0 for 3 cycles -> pkt_o stable.
REQ-042 fencei issued -> pkt_v_o=0 and req_ready_o=0 until fencei_done_i is pulsed at cycle +5; READY the following cycle.
REQ-043 Fill the FIFO with pkt_ready_i=0 -> req_ready_o=0 after 2 accepts. Assert reset_i in FENCE_WAIT -> FIFO empty and READY.
